// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, select width and named operation selects.
// Used by the alu, the execution unit and any bench driving them.
package alu_pkg;

  localparam int unsigned ALU_W = 32;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSll = 3'b101,
    AluSrl = 3'b110,
    AluSlt = 3'b111
  } alu_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
// Ports: a_i/b_i operands, sel_i operation select (alu_sel_e encoding),
//        res_o result, z_o result==0, c_o carry, v_o signed overflow.
// Carry: ADD gives the carry out; SUB gives the carry out of a + ~b + 1, i.e. 1 when there
// is no borrow (a >= b unsigned). Logic, shift and SLT operations give c=0, v=0.
// Shifts use b_i[4:0] as the shift amount; SLT is a signed compare giving 0 or 1.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [ALU_W-1:0] res_o,
  output logic             z_o,
  output logic             c_o,
  output logic             v_o
);

  localparam int unsigned ShW = $clog2(ALU_W);
  localparam int unsigned Msb = ALU_W - 1;

  logic [ALU_W:0] sum;
  logic [ALU_W:0] diff;
  logic           v_add;
  logic           v_sub;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} + {1'b0, ~b_i} + {{ALU_W{1'b0}}, 1'b1};
  assign v_add = (a_i[Msb] == b_i[Msb]) && (sum[Msb] != a_i[Msb]);
  assign v_sub = (a_i[Msb] != b_i[Msb]) && (diff[Msb] != a_i[Msb]);

  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    case (alu_sel_e'(sel_i))
      AluAdd: begin
        res_o = sum[ALU_W-1:0];
        c_o   = sum[ALU_W];
        v_o   = v_add;
      end
      AluSub: begin
        res_o = diff[ALU_W-1:0];
        c_o   = diff[ALU_W];
        v_o   = v_sub;
      end
      AluAnd: res_o = a_i & b_i;
      AluOr:  res_o = a_i | b_i;
      AluXor: res_o = a_i ^ b_i;
      AluSll: res_o = a_i << b_i[ShW-1:0];
      AluSrl: res_o = a_i >> b_i[ShW-1:0];
      // Signed less-than: sign of the difference corrected by overflow.
      AluSlt: res_o = {{(ALU_W-1){1'b0}}, diff[Msb] ^ v_sub};
    endcase
  end

  assign z_o = (res_o == '0);

endmodule

// File: rtl/alu_rsp_fifo.sv
// Response FIFO, DEPTH entries of W bits, head presented combinationally.
// Ports: clk_i, rst_i (async active-high), push_i/push_data_i write the tail,
//        pop_i advances the head, head_o current head entry, count_o occupancy.
// The caller must not push when full without popping, nor pop when empty.
module alu_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) count_d = count_q + (PtrW+1)'(1);
    if (pop_i && !push_i) count_d = count_q - (PtrW+1)'(1);
  end

  // Storage is reset so the head reads zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop_i) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution front-end: request regs -> alu -> response FIFO.
// Ports: clk_i, rst_i (async active-high);
//        req_valid_i/req_ready_o with req_opa_i, req_opb_i, req_sel_i, req_tag_i;
//        rsp_valid_o/rsp_ready_i with rsp_res_o, rsp_z_o, rsp_c_o, rsp_v_o, rsp_tag_o;
//        flags_clr_i clears sticky_zcv_o; op_count_o counts enqueued results (wraps).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ALU_W-1:0] req_opa_i,
  input  logic [ALU_W-1:0] req_opb_i,
  input  logic [SEL_W-1:0] req_sel_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ALU_W-1:0] rsp_res_o,
  output logic             rsp_z_o,
  output logic             rsp_c_o,
  output logic             rsp_v_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  input  logic             flags_clr_i,
  output logic [2:0]       sticky_zcv_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = ALU_W + 3 + TAG_W;

  logic             s1_valid_q;
  logic [ALU_W-1:0] s1_opa_q, s1_opb_q;
  logic [SEL_W-1:0] s1_sel_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             accept, push, pop;
  logic [ALU_W-1:0] alu_res;
  logic             alu_z, alu_c, alu_v;
  logic [EntW-1:0]  head;
  logic [PtrW:0]    count;
  logic [PtrW+1:0]  used;

  logic [2:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // Credit check uses only registered state: a slot is held for the op in stage 1,
  // so stage 1 can always push on the following edge.
  assign used        = {1'b0, count} + (PtrW+2)'(s1_valid_q);
  assign req_ready_o = used < (PtrW+2)'(DEPTH);
  assign accept      = req_valid_i && req_ready_o;
  assign push        = s1_valid_q;
  assign rsp_valid_o = (count != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_opa_q   <= '0;
      s1_opb_q   <= '0;
      s1_sel_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_opa_q <= req_opa_i;
        s1_opb_q <= req_opb_i;
        s1_sel_q <= req_sel_i;
        s1_tag_q <= req_tag_i;
      end
    end
  end

  alu u_alu (
    .a_i   (s1_opa_q),
    .b_i   (s1_opb_q),
    .sel_i (s1_sel_q),
    .res_o (alu_res),
    .z_o   (alu_z),
    .c_o   (alu_c),
    .v_o   (alu_v)
  );

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (EntW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i ({alu_res, alu_z, alu_c, alu_v, s1_tag_q}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign {rsp_res_o, rsp_z_o, rsp_c_o, rsp_v_o, rsp_tag_o} = head;

  // Clear takes priority over a same-edge push.
  always_comb begin
    sticky_d   = sticky_q;
    op_count_d = op_count_q;
    if (push) begin
      sticky_d   = sticky_q | {alu_z, alu_c, alu_v};
      op_count_d = op_count_q + CNT_W'(1);
    end
    if (flags_clr_i) sticky_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q   <= '0;
      op_count_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  assign sticky_zcv_o = sticky_q;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit against a queue-based transaction model.
module tb_alu_exec_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic [3:0]  tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_sel = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_res;
  logic        rsp_z, rsp_c, rsp_v;
  logic [3:0]  rsp_tag;
  logic        flags_clr = 1'b0;
  logic [2:0]  sticky;
  logic [15:0] op_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Transaction model state.
  ent_t        exp_q[$];
  logic        m_s1_v = 1'b0;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_sel;
  logic [3:0]  m_tag;
  logic [2:0]  m_sticky = '0;
  logic [15:0] m_count = '0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .DEPTH (DEPTH),
    .TAG_W (4),
    .CNT_W (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_opa_i    (req_a),
    .req_opb_i    (req_b),
    .req_sel_i    (req_sel),
    .req_tag_i    (req_tag),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_res_o    (rsp_res),
    .rsp_z_o      (rsp_z),
    .rsp_c_o      (rsp_c),
    .rsp_v_o      (rsp_v),
    .rsp_tag_o    (rsp_tag),
    .flags_clr_i  (flags_clr),
    .sticky_zcv_o (sticky),
    .op_count_o   (op_count)
  );

  function automatic ent_t ref_alu(input logic [2:0] sel, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
    ent_t   e;
    longint ua, ub, sa, sb, t;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    e.tag = tag;
    case (sel)
      3'd0: begin
        t = ua + ub;
        e.res = t[31:0];
        e.c = (t >= 64'sh1_0000_0000);
        t = sa + sb;
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        e.c = (a >= b);
        t = sa - sb;
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = a << b[4:0];
      3'd6: e.res = a >> b[4:0];
      default: e.res = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic ent_t dut_head();
    return {rsp_res, rsp_z, rsp_c, rsp_v, rsp_tag};
  endfunction

  function automatic logic m_ready();
    return (exp_q.size() + int'(m_s1_v)) < DEPTH;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_s1_v = 1'b0;
    m_sticky = '0;
    m_count = '0;
  endtask

  // Advance one clock edge (called at posedge+1) and update the model for that edge.
  task automatic tick();
    logic acc, pop;
    ent_t e;
    acc = req_valid && m_ready();
    pop = rsp_ready && (exp_q.size() > 0);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (m_s1_v) begin
      e = ref_alu(m_sel, m_a, m_b, m_tag);
      exp_q.push_back(e);
      m_count++;
      m_sticky |= {e.z, e.c, e.v};
    end
    if (flags_clr) m_sticky = '0;
    m_s1_v = acc;
    if (acc) begin
      m_a = req_a; m_b = req_b; m_sel = req_sel; m_tag = req_tag;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    req_valid = v; req_sel = s; req_a = a; req_b = b; req_tag = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, '0, '0, '0);
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    #1;
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready got %b want 1", req_ready); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    vec_cnt++; if (sticky !== 3'b000) begin err_cnt++; $display("FAIL rst_sticky got %b want 000", sticky); end
    vec_cnt++; if (op_count !== 16'd0) begin err_cnt++; $display("FAIL rst_count got %0d want 0", op_count); end
    vec_cnt++; if (rsp_res !== 32'd0) begin err_cnt++; $display("FAIL rst_res got %h want 0", rsp_res); end
    @(posedge clk); #1;
    // Queue two entries, then reset mid-stream.
    drive(1'b1, 3'd1, 32'd1, 32'd1, 4'd1); tick();
    drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 4'd2); tick();
    drive(1'b0, 3'd0, '0, '0, '0); tick();
    vec_cnt++; if (op_count !== 16'd2) begin err_cnt++; $display("FAIL pre_rst_count got %0d want 2", op_count); end
    vec_cnt++; if (sticky !== 3'b110) begin err_cnt++; $display("FAIL pre_rst_sticky got %b want 110", sticky); end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL async_rst_valid got %b want 0", rsp_valid); end
    vec_cnt++; if (op_count !== 16'd0) begin err_cnt++; $display("FAIL async_rst_count got %0d want 0", op_count); end
    vec_cnt++; if (sticky !== 3'b000) begin err_cnt++; $display("FAIL async_rst_sticky got %b want 000", sticky); end
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    #1;
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_ovf();
    rsp_ready = 1'b1;
    drive(1'b1, 3'd0, 32'h4000_0000, 32'h4000_0000, 4'd3);
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL add_ready got %b want 1", req_ready); end
    tick();
    drive(1'b0, 3'd0, '0, '0, '0);
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL add_early_valid got %b want 0", rsp_valid); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL add_valid got %b want 1", rsp_valid); end
    vec_cnt++;
    if (dut_head() !== {32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'd3}) begin
      err_cnt++; $display("FAIL add_ovf got %h want %h", dut_head(), {32'h8000_0000, 3'b001, 4'd3});
    end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL add_drained got %b want 0", rsp_valid); end
  endtask

  task automatic test_carry_zero();
    rsp_ready = 1'b1;
    drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0004, 4'd1); tick();
    drive(1'b1, 3'd1, 32'd1, 32'd1, 4'd2); tick();
    drive(1'b0, 3'd0, '0, '0, '0);
    vec_cnt++;
    if ({rsp_valid, rsp_res, rsp_z, rsp_c, rsp_v, rsp_tag} !== {1'b1, 32'd3, 3'b010, 4'd1}) begin
      err_cnt++; $display("FAIL add_carry got v=%b %h want 1 %h", rsp_valid, dut_head(), {32'd3, 3'b010, 4'd1});
    end
    tick();
    vec_cnt++;
    if ({rsp_valid, rsp_res, rsp_z, rsp_tag} !== {1'b1, 32'd0, 1'b1, 4'd2}) begin
      err_cnt++; $display("FAIL sub_zero got v=%b res=%h z=%b tag=%0d want 1 0 1 2", rsp_valid, rsp_res, rsp_z, rsp_tag);
    end
    vec_cnt++; if (sticky !== 3'b111) begin err_cnt++; $display("FAIL sticky_all got %b want 111", sticky); end
    tick();
  endtask

  task automatic test_backpressure();
    int   n_acc;
    ent_t held;
    logic have;
    n_acc = 0;
    have = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'($urandom), pick_operand(), pick_operand(), 4'(8 + i));
      vec_cnt++; if (req_ready !== m_ready()) begin err_cnt++; $display("FAIL bp_ready[%0d] got %b want %b", i, req_ready, m_ready()); end
      if (req_ready) n_acc++;
      if (have) begin
        vec_cnt++; if (dut_head() !== held) begin err_cnt++; $display("FAIL bp_stable[%0d] got %h want %h", i, dut_head(), held); end
      end else if (rsp_valid) begin
        have = 1'b1; held = dut_head();
      end
      tick();
    end
    drive(1'b0, 3'd0, '0, '0, '0);
    vec_cnt++; if (n_acc != DEPTH) begin err_cnt++; $display("FAIL bp_accepted got %0d want %0d", n_acc, DEPTH); end
    vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_full_ready got %b want 0", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      vec_cnt++;
      if (!rsp_valid || rsp_tag !== 4'(8 + i) || dut_head() !== exp_q[0]) begin
        err_cnt++; $display("FAIL bp_drain[%0d] got v=%b %h want %h", i, rsp_valid, dut_head(), exp_q[0]);
      end
      tick();
    end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_empty got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      drive(i < 16, 3'($urandom), pick_operand(), pick_operand(), 4'(i));
      if (i < 16) begin
        vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready[%0d] got %b want 1", i, req_ready); end
      end
      tick();
      if (i >= 1) begin
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'(i - 1) || dut_head() !== exp_q[0]) begin
          err_cnt++; $display("FAIL b2b_rsp[%0d] got v=%b %h want tag %0d", i, rsp_valid, dut_head(), i - 1);
        end
      end
    end
    drive(1'b0, 3'd0, '0, '0, '0);
    tick();
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_end got %b want 0", rsp_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 3'($urandom), pick_operand(), pick_operand(), 4'($urandom));
      rsp_ready = $urandom_range(0, 9) < 6;
      flags_clr = $urandom_range(0, 19) == 0;
      vec_cnt++; if (req_ready !== m_ready()) begin err_cnt++; $display("FAIL rnd_ready[%0d] got %b want %b", i, req_ready, m_ready()); end
      vec_cnt++; if (rsp_valid !== (exp_q.size() > 0)) begin err_cnt++; $display("FAIL rnd_valid[%0d] got %b want %b", i, rsp_valid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        vec_cnt++; if (dut_head() !== exp_q[0]) begin err_cnt++; $display("FAIL rnd_head[%0d] got %h want %h", i, dut_head(), exp_q[0]); end
      end
      vec_cnt++; if (sticky !== m_sticky) begin err_cnt++; $display("FAIL rnd_sticky[%0d] got %b want %b", i, sticky, m_sticky); end
      vec_cnt++; if (op_count !== m_count) begin err_cnt++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, op_count, m_count); end
      tick();
    end
    flags_clr = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0);
    rsp_ready = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_flags_wrap();
    int n;
    rsp_ready = 1'b1;
    n = 16'hFFFF - int'(m_count);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 3'd4, $urandom, $urandom, 4'(i));
      tick();
    end
    drive(1'b0, 3'd0, '0, '0, '0);
    repeat (3) tick();
    vec_cnt++; if (op_count !== 16'hFFFF) begin err_cnt++; $display("FAIL wrap_pre got %h want ffff", op_count); end
    drive(1'b1, 3'd1, 32'd7, 32'd7, 4'd5);
    tick();
    drive(1'b0, 3'd0, '0, '0, '0);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    vec_cnt++; if (sticky !== 3'b000) begin err_cnt++; $display("FAIL clr_wins got %b want 000", sticky); end
    vec_cnt++; if (op_count !== 16'h0000) begin err_cnt++; $display("FAIL wrap got %h want 0000", op_count); end
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_z !== 1'b1 || rsp_tag !== 4'd5) begin
      err_cnt++; $display("FAIL clr_push got v=%b z=%b tag=%0d want 1 1 5", rsp_valid, rsp_z, rsp_tag);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_carry_zero();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_flags_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
